// File: rtl/ddc_pkg.sv
// ddc_pkg -- shared definitions for the ddc_decim down-converter.
//   clog2 / acc_w_f / dw_f : width derivation helpers
//   saturate                : clamp a 64-bit signed value to a w-bit signed range
//   iq_pair_t               : I/Q pair at the default output width, for consumers
package ddc_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Accumulator width: full product plus growth for DECIM_MAX additions.
    function automatic int acc_w_f(input int adc_w, input int lo_w, input int decim_max);
        return adc_w + lo_w + clog2(decim_max);
    endfunction

    // Decimation field width: must hold DECIM_MAX itself.
    function automatic int dw_f(input int decim_max);
        return clog2(decim_max + 1);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    localparam int IQ_W = 24;

    typedef struct packed {
        logic signed [IQ_W-1:0] i;
        logic signed [IQ_W-1:0] q;
    } iq_pair_t;

endpackage

// File: rtl/ddc_fifo.sv
// ddc_fifo -- synchronous show-ahead FIFO with a registered head output.
//   adc_clk, reset : clock, synchronous active-high reset
//   i_wr, i_wdata  : write request / data (ignored when full unless read same cycle)
//   i_rd           : pop head when o_valid
//   o_valid        : non-empty
//   o_full         : DEPTH entries held
//   o_rdata        : head entry (register; holds last value when empty)
// DEPTH must be a power of two, >= 2.
module ddc_fifo
    import ddc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic         adc_clk,
    input  logic         reset,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic         o_valid,
    output logic         o_full,
    output logic [W-1:0] o_rdata
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_head;

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_ptr_n;
    logic [CW-1:0] w_rem;

    assign o_valid    = (r_count != '0);
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_rdata    = r_head;
    assign w_pop      = o_valid && i_rd;
    // A read frees a slot in the same cycle, so a write on full is accepted then.
    assign w_push     = i_wr && (!o_full || w_pop);
    assign w_rd_ptr_n = r_rd_ptr + AW'(w_pop);
    // Entries of the old contents that survive this cycle's pop.
    assign w_rem      = r_count - CW'(w_pop);

    always_ff @(posedge adc_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            // New write becomes head only if nothing older remains; otherwise
            // a pop promotes the next stored entry.
            if (w_push && (w_rem == '0))
                r_head <= i_wdata;
            else if (w_pop && (w_rem != '0))
                r_head <= r_mem[w_rd_ptr_n];
        end
    end

endmodule

// File: rtl/ddc_decim.sv
// ddc_decim -- complex DDC back end: ADC x LO mix, integrate-and-dump over R
// samples, arithmetic-shift scaling with saturation, output FIFO.
//   adc_clk, reset              : clock, synchronous active-high reset
//   i_adc_data/i_adc_valid      : signed sample and qualifier
//   i_lo_sin/i_lo_cos           : LO, aligned with the sample
//   i_decim                     : R (0 -> 1, >DECIM_MAX -> DECIM_MAX), latched per block
//   i_shift                     : right shift of the dump, latched per block
//   o_out_valid/i_out_ready     : FIFO handshake, o_out_i/o_out_q head pair
//   o_overflow/o_sat            : sticky drop / clip flags, cleared by i_clear_flags
// Build option: DDC_ROUND_EN adds 2^(shift-1) before the shift (round half up);
// without it the shift truncates toward -inf.
module ddc_decim
    import ddc_pkg::*;
#(
    parameter  int ADC_W      = 14,
    parameter  int LO_W       = 20,
    parameter  int OUT_W      = 24,
    parameter  int DECIM_MAX  = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int DW         = dw_f(DECIM_MAX)
) (
    input  logic                    adc_clk,
    input  logic                    reset,
    input  logic signed [ADC_W-1:0] i_adc_data,
    input  logic                    i_adc_valid,
    input  logic signed [LO_W-1:0]  i_lo_sin,
    input  logic signed [LO_W-1:0]  i_lo_cos,
    input  logic [DW-1:0]           i_decim,
    input  logic [5:0]              i_shift,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic signed [OUT_W-1:0] o_out_i,
    output logic signed [OUT_W-1:0] o_out_q,
    output logic                    o_overflow,
    output logic                    o_sat,
    input  logic                    i_clear_flags
);
    localparam int PW    = ADC_W + LO_W;
    localparam int ACC_W = acc_w_f(ADC_W, LO_W, DECIM_MAX);

    // Stage 1: input capture. decim/shift travel with the sample so the block
    // start sees the values present when its first sample was taken.
    logic signed [ADC_W-1:0] r_adc;
    logic signed [LO_W-1:0]  r_sin, r_cos;
    logic                    r_v1;
    logic [DW-1:0]           r_decim1;
    logic [5:0]              r_shift1;

    // Stage 2: products
    logic signed [PW-1:0]    r_prod_i, r_prod_q;
    logic                    r_v2;
    logic [DW-1:0]           r_decim2;
    logic [5:0]              r_shift2;

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_adc    <= '0;
            r_sin    <= '0;
            r_cos    <= '0;
            r_v1     <= 1'b0;
            r_decim1 <= '0;
            r_shift1 <= '0;
            r_prod_i <= '0;
            r_prod_q <= '0;
            r_v2     <= 1'b0;
            r_decim2 <= '0;
            r_shift2 <= '0;
        end else begin
            r_adc    <= i_adc_data;
            r_sin    <= i_lo_sin;
            r_cos    <= i_lo_cos;
            r_v1     <= i_adc_valid;
            r_decim1 <= i_decim;
            r_shift1 <= i_shift;
            r_prod_i <= PW'(r_adc) * PW'(r_cos);
            r_prod_q <= PW'(r_adc) * PW'(r_sin);
            r_v2     <= r_v1;
            r_decim2 <= r_decim1;
            r_shift2 <= r_shift1;
        end
    end

    // Stage 3: integrate and dump
    logic [DW-1:0]           r_cnt;
    logic [DW-1:0]           r_blk_r;
    logic [5:0]              r_blk_sh;
    logic signed [ACC_W-1:0] r_acc_i, r_acc_q;
    logic                    r_dump_v;
    logic signed [ACC_W-1:0] r_dump_i, r_dump_q;
    logic [5:0]              r_dump_sh;

    logic                    w_first;
    logic                    w_last;
    logic [DW-1:0]           w_r_in;
    logic [DW-1:0]           w_r_eff;
    logic [5:0]              w_sh_eff;
    logic signed [ACC_W-1:0] w_pext_i, w_pext_q;
    logic signed [ACC_W-1:0] w_sum_i, w_sum_q;

    assign w_r_in   = (r_decim2 == '0)                ? DW'(1) :
                      (r_decim2 > DW'(DECIM_MAX))     ? DW'(DECIM_MAX) : r_decim2;
    assign w_first  = (r_cnt == '0);
    assign w_r_eff  = w_first ? w_r_in   : r_blk_r;
    assign w_sh_eff = w_first ? r_shift2 : r_blk_sh;
    assign w_last   = ((r_cnt + DW'(1)) == w_r_eff);
    assign w_pext_i = {{(ACC_W-PW){r_prod_i[PW-1]}}, r_prod_i};
    assign w_pext_q = {{(ACC_W-PW){r_prod_q[PW-1]}}, r_prod_q};
    // First sample of a block starts from zero instead of the stale accumulator.
    assign w_sum_i  = (w_first ? '0 : r_acc_i) + w_pext_i;
    assign w_sum_q  = (w_first ? '0 : r_acc_q) + w_pext_q;

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_blk_r   <= DW'(1);
            r_blk_sh  <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_dump_v  <= 1'b0;
            r_dump_i  <= '0;
            r_dump_q  <= '0;
            r_dump_sh <= '0;
        end else begin
            r_dump_v <= 1'b0;
            if (r_v2) begin
                if (w_first) begin
                    r_blk_r  <= w_r_in;
                    r_blk_sh <= r_shift2;
                end
                if (w_last) begin
                    r_dump_v  <= 1'b1;
                    r_dump_i  <= w_sum_i;
                    r_dump_q  <= w_sum_q;
                    r_dump_sh <= w_sh_eff;
                    r_cnt     <= '0;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_cnt   <= r_cnt + DW'(1);
                end
            end
        end
    end

    // Stage 4: scale and saturate, done in 64 bits so rounding cannot wrap.
    logic signed [63:0] w_ext_i, w_ext_q, w_rnd;
    logic signed [63:0] w_shd_i, w_shd_q;
    logic signed [63:0] w_sat_i, w_sat_q;
    logic               w_clip;

    assign w_ext_i = {{(64-ACC_W){r_dump_i[ACC_W-1]}}, r_dump_i};
    assign w_ext_q = {{(64-ACC_W){r_dump_q[ACC_W-1]}}, r_dump_q};
`ifdef DDC_ROUND_EN
    assign w_rnd   = (r_dump_sh != '0) ? (64'sd1 <<< (r_dump_sh - 6'd1)) : 64'sd0;
`else
    assign w_rnd   = 64'sd0;
`endif
    assign w_shd_i = (w_ext_i + w_rnd) >>> r_dump_sh;
    assign w_shd_q = (w_ext_q + w_rnd) >>> r_dump_sh;
    assign w_sat_i = saturate(w_shd_i, OUT_W);
    assign w_sat_q = saturate(w_shd_q, OUT_W);
    assign w_clip  = (w_sat_i != w_shd_i) || (w_sat_q != w_shd_q);

    logic                    r_s4_v;
    logic signed [OUT_W-1:0] r_s4_i, r_s4_q;
    logic                    r_s4_clip;
    logic                    r_ovf, r_sat;
    logic                    w_full;
    logic                    w_ovf_set;
    logic [2*OUT_W-1:0]      w_head;

    assign w_ovf_set = r_s4_v && w_full && !(o_out_valid && i_out_ready);

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_s4_v    <= 1'b0;
            r_s4_i    <= '0;
            r_s4_q    <= '0;
            r_s4_clip <= 1'b0;
            r_ovf     <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_s4_v    <= r_dump_v;
            r_s4_i    <= w_sat_i[OUT_W-1:0];
            r_s4_q    <= w_sat_q[OUT_W-1:0];
            r_s4_clip <= r_dump_v && w_clip;
            // A same-cycle set beats clear_flags.
            if (w_ovf_set)          r_ovf <= 1'b1;
            else if (i_clear_flags) r_ovf <= 1'b0;
            if (r_s4_v && r_s4_clip) r_sat <= 1'b1;
            else if (i_clear_flags)  r_sat <= 1'b0;
        end
    end

    ddc_fifo #(.DEPTH(FIFO_DEPTH), .W(2*OUT_W)) u_fifo (
        .adc_clk (adc_clk),
        .reset   (reset),
        .i_wr    (r_s4_v),
        .i_wdata ({r_s4_i, r_s4_q}),
        .i_rd    (i_out_ready),
        .o_valid (o_out_valid),
        .o_full  (w_full),
        .o_rdata (w_head)
    );

    assign o_out_i    = w_head[2*OUT_W-1:OUT_W];
    assign o_out_q    = w_head[OUT_W-1:0];
    assign o_overflow = r_ovf;
    assign o_sat      = r_sat;

endmodule
